// File: rtl/key_reader.sv
// key_reader: debounces up to four active-low push buttons, tracks a
// debounced level per key and reports press, long-press and release events
// through a 4-entry FIFO with a valid/ready consumer interface.
//
// Handshake: evt_valid is high whenever the FIFO holds an entry. evt_key and
// evt_type show the oldest entry and stay stable until it is accepted. The
// head is removed on a rising clk_in edge where evt_valid and evt_ready are
// both high. evt_ready has no effect while evt_valid is low.
module key_reader #(
    parameter int          NUM_KEYS     = 3,
    parameter int unsigned DEBOUNCE_CYC = 240_000,
    parameter int unsigned LONG_CYC     = 24_000_000
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [1:0]          evt_key,
    output logic [1:0]          evt_type,
    output logic                evt_ovf
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LW = $clog2(LONG_CYC + 1);

    localparam logic [1:0] T_PRESS   = 2'b00;
    localparam logic [1:0] T_RELEASE = 2'b01;
    localparam logic [1:0] T_LONG    = 2'b10;

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] state_q;
    logic [DW-1:0]       deb_cnt  [NUM_KEYS];
    logic [LW-1:0]       hold_cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0] pend_press, pend_long, pend_rel;
    logic [NUM_KEYS-1:0] raise_press, raise_long, raise_rel;
    logic [NUM_KEYS-1:0] take_press, take_long, take_rel;

    logic [3:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;
    logic       push, pop, can_push;
    logic [1:0] push_key, push_type;

    // Two-flop synchronizer; idles at 1 (button released) out of reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // Per-key debounce and hold counters plus the delayed level for edge detection.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            key_state <= '0;
            state_q   <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                deb_cnt[k]  <= '0;
                hold_cnt[k] <= '0;
            end
        end else begin
            state_q <= key_state;
            for (int k = 0; k < NUM_KEYS; k++) begin
                // Buttons are active-low, key_state is active-high.
                if ((~sync2[k]) == key_state[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DW'(DEBOUNCE_CYC - 1)) begin
                    key_state[k] <= ~key_state[k];
                    deb_cnt[k]   <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end

                if (!key_state[k]) begin
                    hold_cnt[k] <= '0;
                end else if (hold_cnt[k] != LW'(LONG_CYC - 1)) begin
                    hold_cnt[k] <= hold_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Event sources: level edges, and the single cycle the hold counter hits its limit.
    always_comb begin
        raise_press = key_state & ~state_q;
        raise_rel   = ~key_state & state_q;
        raise_long  = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            raise_long[k] = key_state[k] &&
                            ((hold_cnt[k] + LW'(1)) == LW'(LONG_CYC - 1));
        end
    end

    // Fixed-priority pick of one pending flag: lowest key, then press, long, release.
    always_comb begin
        take_press = '0;
        take_long  = '0;
        take_rel   = '0;
        push       = 1'b0;
        push_key   = 2'b00;
        push_type  = T_PRESS;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (!push && can_push) begin
                if (pend_press[k]) begin
                    take_press[k] = 1'b1;
                    push          = 1'b1;
                    push_key      = 2'(k);
                    push_type     = T_PRESS;
                end else if (pend_long[k]) begin
                    take_long[k] = 1'b1;
                    push         = 1'b1;
                    push_key     = 2'(k);
                    push_type    = T_LONG;
                end else if (pend_rel[k]) begin
                    take_rel[k] = 1'b1;
                    push        = 1'b1;
                    push_key    = 2'(k);
                    push_type   = T_RELEASE;
                end
            end
        end
    end

    // Pending flags; a flag raised while still waiting is a lost event and trips the sticky overflow.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pend_press <= '0;
            pend_long  <= '0;
            pend_rel   <= '0;
            evt_ovf    <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~take_press) | raise_press;
            pend_long  <= (pend_long  & ~take_long)  | raise_long;
            pend_rel   <= (pend_rel   & ~take_rel)   | raise_rel;
            if (|(raise_press & pend_press & ~take_press) ||
                |(raise_long  & pend_long  & ~take_long)  ||
                |(raise_rel   & pend_rel   & ~take_rel)) begin
                evt_ovf <= 1'b1;
            end
        end
    end

    // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
    assign pop      = evt_valid & evt_ready;
    assign can_push = (count != 3'd4) || pop;

    // Event FIFO storage and pointers.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {push_key, push_type};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign evt_valid = (count != 3'd0);
    assign evt_key   = evt_valid ? fifo_mem[rd_ptr][3:2] : 2'b00;
    assign evt_type  = evt_valid ? fifo_mem[rd_ptr][1:0] : 2'b00;

endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 3, number of push-button inputs (1..4).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 24'd240_000, stable cycles required to accept a level change (10 ms at 24 MHz).
REQ-003 SHALL have parameter LONG_CYC, default 25'd24_000_000, held cycles before a long-press event (1 s).
REQ-004 SHALL have port clk_in, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port key_in, input, NUM_KEYS, raw asynchronous buttons, active-low (0 = pressed).
REQ-007 SHALL have port key_state, output, NUM_KEYS, debounced level, 1 = pressed.
REQ-008 SHALL have port evt_valid, output, 1, event word available.
REQ-009 SHALL have port evt_ready, input, 1, consumer accepts the event.
REQ-010 SHALL have port evt_key, output, 2, key index of the head event.
REQ-011 SHALL have port evt_type, output, 2, 00 press, 01 release, 10 long, 11 unused.
REQ-012 SHALL have port evt_ovf, output, 1, sticky: an event was lost.

Function
REQ-013 SHALL pass each key_in bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep one debounce counter per key, cleared in any cycle where the synchronized level equals the current debounced level.
REQ-015 SHALL flip the key_state bit, and clear the counter, in the cycle after the counter reaches DEBOUNCE_CYC-1 with the level still differing; a glitch shorter than DEBOUNCE_CYC cycles SHALL cause no change.
REQ-016 SHALL raise a per-key pending-press flag on a 0->1 key_state transition and a pending-release flag on a 1->0 transition.
REQ-017 SHALL keep one hold counter per key that counts while key_state=1, clears while 0, and saturates after reaching LONG_CYC-1.
REQ-018 SHALL raise the pending-long flag exactly once per press, in the cycle the hold counter reaches LONG_CYC-1; a release before then SHALL produce no long event.
REQ-019 SHALL, each cycle with the FIFO not full, move one pending flag into a 4-entry event FIFO: lowest key index first, then press, long, release within a key; the moved flag clears.
REQ-020 SHALL set evt_ovf when a pending flag is raised while already set; pending flags never drop silently otherwise.
REQ-021 SHALL drive evt_valid=1 whenever the FIFO is non-empty, with evt_key/evt_type showing the oldest entry and held stable until accepted.
REQ-022 SHALL pop the head on the rising edge where evt_valid=1 and evt_ready=1; evt_ready while empty SHALL have no effect.
REQ-023 SHALL, on a simultaneous push and pop with the FIFO full, accept both (occupancy unchanged).
REQ-024 SHALL achieve a latency of 2 + DEBOUNCE_CYC + 2 cycles from a clean key_in edge to evt_valid, given an empty FIFO and no competing pending flags.
REQ-025 SHALL size all counters to hold their parameter value without overflow.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set synchronizers to 1 (released), key_state=0, all counters=0, all pending flags=0, FIFO empty, evt_valid=0, evt_key=0, evt_type=0, evt_ovf=0.
REQ-027 SHALL clear evt_ovf only by reset.
REQ-028 SHALL treat a key held through reset release as a new press: press event after the normal debounce latency.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20, NUM_KEYS=3)
REQ-029 SHALL verify: key_in[1] 1->0 held, evt_ready=1 -> key_state=3'b010 after 6 cycles, evt_valid pulse with evt_key=1, evt_type=00 at cycle 8.
REQ-030 SHALL verify: key_in[0] low for 3 cycles then high -> key_state stays 0, no event.
REQ-031 SHALL verify: key_in[2] held 30 cycles then released -> events press, long, release in order, each once, evt_key=2.
REQ-032 SHALL verify: key_in[0] and key_in[2] pressed same cycle, evt_ready=0 -> FIFO holds key0 press then key2 press; evt_ready=1 drains them in that order.
REQ-033 SHALL verify: evt_ready=0 with 5+ press/release cycles on key 1 -> FIFO full at 4, evt_ovf=1 once a pending flag is re-raised; evt_ovf stays 1 until rst_n=0.
REQ-034 SHALL verify: rst_n pulsed low while key_in[1] held low and FIFO non-empty -> outputs at reset values, then a fresh key1 press event 8 cycles after rst_n returns high.
